// File: rtl/wb_regfile_if.sv
// Signal bundle between the MEM/WB pipeline side and the write-back register file.
// The master drives the MEM/WB bundle and the read addresses. The slave returns the read data and the write count.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 32
);
    logic [DATA_W+AW:0] wb_in;
    logic [AW-1:0]      rs1_addr;
    logic [AW-1:0]      rs2_addr;
    logic [AW-1:0]      dbg_addr;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [DATA_W-1:0]  dbg_data;
    logic [CNT_W-1:0]   wr_count;

    modport master (
        output wb_in, rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wr_count
    );

    modport slave (
        input  wb_in, rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file. It has two bypassed read ports and one debug read port.
// It also counts committed writes; the counter wraps.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_regfile_if.slave    bus
);
    localparam int AW = $clog2(NREGS);

    logic                 wr_en;
    logic [AW-1:0]        wr_rd;
    logic [DATA_W-1:0]    wr_data;
    logic                 commit;

    logic [DATA_W-1:0]    regs_q [NREGS];
    logic [DATA_W-1:0]    regs_d [NREGS];
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    assign wr_en   = bus.wb_in[DATA_W+AW];
    assign wr_rd   = bus.wb_in[DATA_W+AW-1:DATA_W];
    assign wr_data = bus.wb_in[DATA_W-1:0];
    assign commit  = wr_en && (wr_rd != '0);

    // Write-first read. Register 0 reads zero. There is no bypass while in reset.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     addr,
        input logic [DATA_W-1:0] stored,
        input logic              byp_ok
    );
        logic [DATA_W-1:0] res;
        res = stored;
        if (addr == '0) begin
            res = '0;
        end else if (byp_ok && wr_en && (wr_rd == addr)) begin
            res = wr_data;
        end
        return res;
    endfunction

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (commit) begin
            regs_d[wr_rd] = wr_data;
            cnt_d         = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        bus.rs1_data = read_port(bus.rs1_addr, regs_q[bus.rs1_addr], !rst);
        bus.rs2_data = read_port(bus.rs2_addr, regs_q[bus.rs2_addr], !rst);
        bus.dbg_data = read_port(bus.dbg_addr, regs_q[bus.dbg_addr], 1'b0);
    end

    assign bus.wr_count = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile. Directed scenarios are followed by randomized write-back traffic.
// All outputs are compared each cycle against an array-based reference model.
module tb_wb_regfile;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    bit   chk_en;
    int   n_checks;
    int   n_err;

    logic [31:0]      model_regs [32];
    logic [CNT_W-1:0] model_cnt;

    wb_regfile_if #(.DATA_W(32), .AW(5), .CNT_W(CNT_W)) bus ();

    wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.wb_in = {we, rd, data};
    endtask

    // Reference read: zero for register 0, write-first bypass only outside reset.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst === 1'b0 && bus.wb_in[37] === 1'b1 && bus.wb_in[36:32] == a)
            return bus.wb_in[31:0];
        return model_regs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'h0;
            model_cnt <= '0;
        end else if (bus.wb_in[37] === 1'b1 && bus.wb_in[36:32] != 5'd0) begin
            model_regs[bus.wb_in[36:32]] <= bus.wb_in[31:0];
            model_cnt <= model_cnt + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rs1_model", bus.rs1_data, exp_read(bus.rs1_addr, 1'b1));
            check("rs2_model", bus.rs2_data, exp_read(bus.rs2_addr, 1'b1));
            check("dbg_model", bus.dbg_data, exp_read(bus.dbg_addr, 1'b0));
            check("cnt_model", 32'(bus.wr_count), 32'(model_cnt));
        end
    end

    initial begin
        logic       we;
        logic [4:0] rd;
        n_checks = 0;
        n_err    = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd3;
        bus.dbg_addr = 5'd3;
        drive(1'b1, 5'd3, 32'h0000_DEAD);

        // Reset is held for two edges while a write to register 3 is presented.
        step();
        chk_en = 1'b1;
        step();
        check("rst_rs1_nobypass", bus.rs1_data, 32'h0);
        check("rst_dbg3", bus.dbg_data, 32'h0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            #1;
            check("rst_dbg_all", bus.dbg_data, 32'h0);
        end
        check("rst_cnt", 32'(bus.wr_count), 32'd0);

        // Write register 7, then read it back on the debug port.
        drive(1'b1, 5'd7, 32'h1234_5678);
        step();
        drive(1'b0, 5'd0, 32'h0);
        bus.dbg_addr = 5'd7;
        #1;
        check("wr_dbg7", bus.dbg_data, 32'h1234_5678);
        check("wr_cnt1", 32'(bus.wr_count), 32'd1);

        // Bypass on register 9 while it still holds 1.
        drive(1'b1, 5'd9, 32'h0000_0001);
        step();
        drive(1'b1, 5'd9, 32'hCAFE_F00D);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd9;
        bus.dbg_addr = 5'd9;
        #1;
        check("byp_rs1", bus.rs1_data, 32'hCAFE_F00D);
        check("byp_rs2", bus.rs2_data, 32'hCAFE_F00D);
        check("byp_dbg_old", bus.dbg_data, 32'h0000_0001);
        step();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        check("byp_dbg_new", bus.dbg_data, 32'hCAFE_F00D);
        check("byp_cnt", 32'(bus.wr_count), 32'd3);

        // A write to register 0 is ignored.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus.rs1_addr = 5'd0;
        #1;
        check("x0_same", bus.rs1_data, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x0_next", bus.rs1_data, 32'h0);
        check("x0_cnt", 32'(bus.wr_count), 32'd3);

        // Reset asserted together with a write to register 4.
        drive(1'b1, 5'd4, 32'h0000_00A5);
        step();
        rst = 1'b1;
        drive(1'b1, 5'd4, 32'h0000_005A);
        bus.dbg_addr = 5'd4;
        bus.rs1_addr = 5'd4;
        #1;
        check("mrst_dbg_pre", bus.dbg_data, 32'h0000_00A5);
        check("mrst_rs1_nobyp", bus.rs1_data, 32'h0000_00A5);
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        #1;
        check("mrst_dbg4", bus.dbg_data, 32'h0);
        check("mrst_cnt", 32'(bus.wr_count), 32'd0);

        // Seventeen writes to register 1 wrap the 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd1, 32'(100 + i));
            step();
        end
        drive(1'b0, 5'd0, 32'h0);
        bus.dbg_addr = 5'd1;
        #1;
        check("wrap_cnt", 32'(bus.wr_count), 32'd1);
        check("wrap_dbg1", bus.dbg_data, 32'd116);

        // Randomized traffic. X is driven on rd and data when reg_write is low.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            we  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            if (we) drive(1'b1, rd, $urandom);
            else if ($urandom_range(0, 1) == 0) bus.wb_in = {1'b0, 5'bx, 32'bx};
            else drive(1'b0, rd, $urandom);
            bus.rs1_addr = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 7));
            bus.rs2_addr = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
            bus.dbg_addr = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file. Sits directly downstream of the MEM/WB pipeline register and consumes its 38-bit output bundle every cycle.
- Commits write-back results into 32 x 32-bit registers and serves two decode-stage read ports, with same-cycle write-to-read bypass.
- Provides a debug read port and a counter of committed writes for the bench and for performance monitoring.

Parameters:
- DATA_W, 32, register width; the bundle layout below is fixed for 32.
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_in  input  38  MEM/WB bundle: [37] reg_write, [36:32] rd, [31:0] wb_data.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- rs1_data  output  32  read port 1 data, combinational.
- rs2_data  output  32  read port 2 data, combinational.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  debug read data, combinational, no bypass.
- wr_count  output  CNT_W  number of committed register writes.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; clock port is clk.
- Reset: on a rising edge with rst=1, all 32 registers clear to 0 and wr_count clears to 0.
  - Reset takes priority over any write presented in the same cycle; that write is dropped and not counted.
- Commit: on a rising edge with rst=0, reg_write=1 and rd!=0, register[rd] <= wb_data and wr_count increments by 1.
  - Write latency is 1 cycle: the value is architecturally visible from the next cycle.
- rd=0 with reg_write=1: no state change and wr_count does not increment. Register 0 always reads 0 on every port.
- reg_write=0: no state change; rd and wb_data are ignored.
- Read ports rs1/rs2, combinational, evaluated in this order:
  - addr==0 gives 0.
  - Otherwise, if reg_write=1 and rd==addr and rst=0, the port returns wb_data (bypass: write-first semantics within the cycle).
  - Otherwise the port returns register[addr].
  - While rst=1, reads return the stored register value; there is no bypass.
- Both read ports may address the same register, and both may hit the bypass simultaneously.
- dbg_data returns register[dbg_addr] with no bypass; dbg_addr==0 gives 0.
- wr_count wraps modulo 2^CNT_W, with no saturation.
- X on wb_in while reg_write=0 must not corrupt state.
- There is no handshake or stall: one bundle is consumed per cycle, matching the unconditional MEM/WB register.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with wb_in={1,5'd3,32'hDEAD} -> every register and dbg_data read 0, wr_count=0, register 3 remains 0.
2. Write then read: wb_in={1,5'd7,32'h1234_5678} for one cycle, then reg_write=0 -> dbg_addr=7 gives 32'h12345678 on the next cycle, wr_count=1.
3. Bypass: rs1_addr=rs2_addr=9 while wb_in={1,5'd9,32'hCAFE_F00D}, with register 9 previously 32'h1 -> both ports show 32'hCAFEF00D in the same cycle, and dbg_data for address 9 shows 32'h1 until the edge.
4. x0 write: wb_in={1,5'd0,32'hFFFF_FFFF} -> rs1_addr=0 reads 0 in the same and the next cycle, wr_count unchanged.
5. Reset mid-stream: write register 4 = 32'hA5, then assert rst together with wb_in={1,5'd4,32'h5A} -> after the edge register 4 = 0 and wr_count = 0.
6. Counter wrap: with CNT_W=4, perform 17 writes to register 1 -> wr_count=1 and register 1 holds the last data written.
